// File: rtl/carry_chain_counter.sv
// Modulo-MOD carry accumulator stage with a registered carry out
// and a four-phase req/ack snapshot port for slow consumers.
module carry_chain_counter #(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CI,
    input  logic             EN,
    input  logic             CLR,
    output logic [WIDTH-1:0] Q,
    output logic             CO,
    input  logic             SNAP_REQ,
    output logic             SNAP_ACK,
    output logic [WIDTH-1:0] SNAP_Q
);

    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
        $error("carry_chain_counter: WIDTH must be 1..16");
    end
    if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_mod
        $error("carry_chain_counter: MOD must be 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] QMAX = WIDTH'(MOD - 1);

    typedef enum logic {
        S_IDLE,
        S_ACK
    } snap_state_t;

    logic             ci_prev;
    logic             ci_rise;
    snap_state_t      state;
    snap_state_t      state_next;
    logic             ack_next;
    logic [WIDTH-1:0] snap_next;

    assign ci_rise = CI & ~ci_prev;

    // Edge history tracks CI unconditionally so EN/CLR never fake a rise.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ci_prev <= 1'b0;
        end else begin
            ci_prev <= CI;
        end
    end

    // Count register: clear beats counting; carry pulses only on wrap.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Q  <= '0;
            CO <= 1'b0;
        end else if (CLR) begin
            Q  <= '0;
            CO <= 1'b0;
        end else if (EN && ci_rise && Q == QMAX) begin
            Q  <= '0;
            CO <= 1'b1;
        end else if (EN && ci_rise) begin
            Q  <= Q + 1'b1;
            CO <= 1'b0;
        end else begin
            CO <= 1'b0;
        end
    end

    // Snapshot handshake state and its registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            SNAP_ACK <= 1'b0;
            SNAP_Q   <= '0;
        end else begin
            state    <= state_next;
            SNAP_ACK <= ack_next;
            SNAP_Q   <= snap_next;
        end
    end

    // Next-state logic: capture pre-update Q on request, hold while acked.
    always_comb begin
        state_next = state;
        ack_next   = 1'b0;
        snap_next  = SNAP_Q;
        unique case (state)
            S_IDLE: begin
                if (SNAP_REQ) begin
                    state_next = S_ACK;
                    ack_next   = 1'b1;
                    snap_next  = Q;
                end
            end
            S_ACK: begin
                if (SNAP_REQ) begin
                    ack_next = 1'b1;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_carry_chain_counter.sv
// Directed bench for carry_chain_counter with MOD=10, WIDTH=4.
// Expected values are hand-computed from the behavioural description.
module tb_carry_chain_counter;

    logic       CLK;
    logic       RST;
    logic       CI;
    logic       EN;
    logic       CLR;
    logic [3:0] Q;
    logic       CO;
    logic       SNAP_REQ;
    logic       SNAP_ACK;
    logic [3:0] SNAP_Q;

    int vecs;
    int errs;

    carry_chain_counter #(.WIDTH(4), .MOD(10)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .CI       (CI),
        .EN       (EN),
        .CLR      (CLR),
        .Q        (Q),
        .CO       (CO),
        .SNAP_REQ (SNAP_REQ),
        .SNAP_ACK (SNAP_ACK),
        .SNAP_Q   (SNAP_Q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse();
        CI = 1'b1;
        step();
        CI = 1'b0;
        step();
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        RST = 1'b1;
        CI = 1'b0;
        EN = 1'b0;
        CLR = 1'b0;
        SNAP_REQ = 1'b0;
        #3;
        chk("rst_q", 16'(Q), 16'd0);
        chk("rst_co", 16'(CO), 16'd0);
        chk("rst_ack", 16'(SNAP_ACK), 16'd0);
        chk("rst_snapq", 16'(SNAP_Q), 16'd0);
        step();
        RST = 1'b0;
        EN = 1'b1;
        step();

        for (int k = 1; k <= 10; k++) begin
            CI = 1'b1;
            step();
            CI = 1'b0;
            chk("wrap_q", 16'(Q), 16'(k % 10));
            chk("wrap_co", 16'(CO), (k == 10) ? 16'd1 : 16'd0);
            step();
            chk("wrap_co_after", 16'(CO), 16'd0);
            step();
        end

        pulse();
        pulse();
        chk("pre_hold_q", 16'(Q), 16'd2);
        CI = 1'b1;
        step();
        chk("hold_first", 16'(Q), 16'd3);
        repeat (4) step();
        chk("hold_stay", 16'(Q), 16'd3);
        CI = 1'b0;
        step();
        pulse();
        chk("hold_next", 16'(Q), 16'd4);

        pulse();
        chk("pre_clr_q", 16'(Q), 16'd5);
        CLR = 1'b1;
        CI = 1'b1;
        step();
        chk("clr_q", 16'(Q), 16'd0);
        chk("clr_co", 16'(CO), 16'd0);
        CLR = 1'b0;
        CI = 1'b0;
        step();
        pulse();
        chk("post_clr_q", 16'(Q), 16'd1);

        repeat (3) pulse();
        chk("pre_en_q", 16'(Q), 16'd4);
        EN = 1'b0;
        repeat (3) pulse();
        chk("en_off_q", 16'(Q), 16'd4);
        CI = 1'b1;
        step();
        EN = 1'b1;
        step();
        step();
        chk("en_raise_q", 16'(Q), 16'd4);
        CI = 1'b0;
        step();
        pulse();
        chk("en_fresh_q", 16'(Q), 16'd5);

        pulse();
        pulse();
        chk("pre_snap_q", 16'(Q), 16'd7);
        SNAP_REQ = 1'b1;
        step();
        chk("snap_ack", 16'(SNAP_ACK), 16'd1);
        chk("snap_q7", 16'(SNAP_Q), 16'd7);
        pulse();
        pulse();
        chk("snap_cnt_q", 16'(Q), 16'd9);
        chk("snap_frozen", 16'(SNAP_Q), 16'd7);
        chk("snap_ack_hold", 16'(SNAP_ACK), 16'd1);
        SNAP_REQ = 1'b0;
        step();
        chk("snap_ack_drop", 16'(SNAP_ACK), 16'd0);
        chk("snap_q_keep", 16'(SNAP_Q), 16'd7);
        SNAP_REQ = 1'b1;
        step();
        chk("snap2_ack", 16'(SNAP_ACK), 16'd1);
        chk("snap2_q9", 16'(SNAP_Q), 16'd9);

        #2;
        RST = 1'b1;
        SNAP_REQ = 1'b0;
        #1;
        chk("arst_q", 16'(Q), 16'd0);
        chk("arst_co", 16'(CO), 16'd0);
        chk("arst_ack", 16'(SNAP_ACK), 16'd0);
        chk("arst_snapq", 16'(SNAP_Q), 16'd0);
        #1;
        RST = 1'b0;
        step();
        pulse();
        chk("post_rst_q", 16'(Q), 16'd1);
        chk("post_rst_ack", 16'(SNAP_ACK), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/carry_chain_counter.md
Name: carry_chain_counter

Overview:
- Downstream stage of the 3-bit mod-8 counter.
- Consumes that counter's one-cycle carry pulse (its Q4 output, high for one CLK cycle per 7->0 wrap) on CI.
- Accumulates carries in a modulo-MOD counter and emits its own registered carry, so stages can be chained into a multi-digit divider/counter.
- Provides a four-phase req/ack snapshot port so a slower consumer can sample a stable count.

Parameters:
- WIDTH, 4, counter width in bits. Legal range 1..16.
- MOD, 10, count modulus. Legal range 2..2^WIDTH; an out-of-range value is a compile-time error.

Ports:
- CLK  input  1  rising-edge clock, same clock as the upstream mod-8 counter
- RST  input  1  asynchronous, active-high reset
- CI  input  1  carry in from the upstream stage; counted once per rising edge of CI
- EN  input  1  count enable; while low, CI edges are ignored
- CLR  input  1  synchronous clear of the count
- Q  output  WIDTH  current count, 0..MOD-1
- CO  output  1  carry out; one-cycle pulse on MOD-1 -> 0 wrap
- SNAP_REQ  input  1  snapshot request (four-phase)
- SNAP_ACK  output  1  snapshot acknowledge
- SNAP_Q  output  WIDTH  captured count, valid while SNAP_ACK=1

Behaviour:
- Interface: one clock, CLK. RST is asynchronous and active-high. All state updates on the rising edge of CLK. RST acts immediately, without waiting for a clock edge.
- Reset values:
  - Q=0, CO=0, SNAP_ACK=0, SNAP_Q=0.
  - Internal ci_prev=0; snapshot FSM in S_IDLE.
  - Reset asserted mid-operation (including mid-handshake) forces these values at once.
- Edge detect:
  - ci_prev <= CI every cycle, regardless of EN and CLR.
  - ci_rise = CI & ~ci_prev.
  - CI held high for N cycles counts exactly once.
  - Raising EN while CI is already high produces no count.
- Count update, in priority order each edge:
  1. CLR=1: Q<=0, CO<=0. A ci_rise in the same cycle is dropped.
  2. EN=1 and ci_rise=1 and Q==MOD-1: Q<=0, CO<=1.
  3. EN=1 and ci_rise=1: Q<=Q+1, CO<=0.
  4. Otherwise: Q holds, CO<=0.
- Latency and width rules:
  - Q changes on the edge that samples the CI rise; latency is one cycle from CI rise to the Q update.
  - CO is registered and coincides with Q returning to 0. It is never high for two consecutive cycles.
  - Arithmetic is unsigned modulo MOD. Q never takes a value >= MOD.
- Snapshot FSM, two states:
  - S_IDLE, SNAP_REQ=1: SNAP_Q <= Q (the value held before this edge's update), SNAP_ACK <= 1, go to S_ACK.
  - S_IDLE, SNAP_REQ=0: stay. SNAP_ACK=0, SNAP_Q holds its last value.
  - S_ACK, SNAP_REQ=1: stay. SNAP_ACK=1, SNAP_Q frozen even while Q keeps counting.
  - S_ACK, SNAP_REQ=0: SNAP_ACK <= 0, go to S_IDLE.
  - A new request is accepted no earlier than the edge after returning to S_IDLE, so minimum handshake turnaround is 2 cycles.
- Independence of handshake and count:
  - CLR does not affect SNAP_Q or the handshake.
  - Counting continues during a handshake.

Test Plan:
- RST pulse, EN=1, MOD=10. Ten 1-cycle CI pulses spaced 3 cycles apart -> Q steps 1..9. The 10th pulse gives Q=0 with CO=1 for exactly one cycle; CO=0 at all other times.
- Q=2, CI held high for 5 cycles -> Q=3 after the first edge, then stays 3. CI low, then a 1-cycle pulse -> Q=4.
- Q=5, CLR=1 and a CI rise in the same cycle -> Q=0, CO=0. Next CI pulse -> Q=1.
- EN=0 with 3 CI pulses at Q=4 -> Q stays 4. Then, with CI high, raise EN -> still Q=4. Next fresh CI rise -> Q=5.
- Q=7, SNAP_REQ=1 -> next edge SNAP_ACK=1, SNAP_Q=7. Two CI pulses follow -> Q=9, SNAP_Q stays 7. SNAP_REQ=0 -> SNAP_ACK=0 on the next edge. Re-raising REQ with Q=9 -> SNAP_Q=9.
- During S_ACK with Q=9, assert RST between clock edges -> Q, CO, SNAP_ACK and SNAP_Q all read 0 immediately, before any CLK edge. After release, the first CI pulse gives Q=1.
